// File: rtl/quantum_pkg.sv
// Shared definitions for the quantum operation interface: opcodes, status codes,
// result byte positions and the active-qubit mask helper.
package quantum_pkg;

  localparam int NUM_QUBITS = 16;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_X       = 4'd1,
    OP_CNOT    = 4'd2,
    OP_CCX     = 4'd3,
    OP_SWAP    = 4'd4,
    OP_LOAD    = 4'd5,
    OP_MEASURE = 4'd6,
    OP_PARITY  = 4'd7
  } opcode_e;

  typedef enum logic [7:0] {
    ST_OK     = 8'd0,
    ST_BAD_OP = 8'd1,
    ST_RANGE  = 8'd2,
    ST_DUP    = 8'd3
  } status_e;

  localparam int RB_REG_LO = 0;
  localparam int RB_REG_HI = 1;
  localparam int RB_OPCODE = 2;
  localparam int RB_STATUS = 3;
  localparam int RB_COUNT  = 4;
  localparam int RB_PARITY = 5;

  // n is the effective qubit count, 1..16.
  function automatic logic [15:0] qubit_mask(input logic [4:0] n);
    logic [16:0] full;
    full = (17'd1 << n) - 17'd1;
    return full[15:0];
  endfunction

endpackage

// File: rtl/quantum_gate_alu.sv
// Combinational gate evaluator: validates operands against the active qubit
// count and produces the next basis register, status and parity.
module quantum_gate_alu
  import quantum_pkg::*;
(
  input  logic [15:0] qreg,
  input  logic [3:0]  code,
  input  logic [3:0]  t,
  input  logic [3:0]  c1,
  input  logic [3:0]  c2,
  input  logic [15:0] load_state,
  input  logic [4:0]  n,
  output logic [15:0] next_qreg,
  output status_e     status,
  output logic        parity
);

  logic [15:0] mask;
  logic        use_t, use_c1, use_c2;
  logic        range_err, dup_err;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block infers a latch.
    mask      = qubit_mask(n);
    use_t     = 1'b0;
    use_c1    = 1'b0;
    use_c2    = 1'b0;
    next_qreg = qreg;
    status    = ST_OK;
    parity    = 1'b0;

    case (code)
      OP_X:             use_t = 1'b1;
      OP_CNOT, OP_SWAP: begin use_t = 1'b1; use_c1 = 1'b1; end
      OP_CCX:           begin use_t = 1'b1; use_c1 = 1'b1; use_c2 = 1'b1; end
      default: ;
    endcase

    range_err = (use_t  && ({1'b0, t}  >= n)) ||
                (use_c1 && ({1'b0, c1} >= n)) ||
                (use_c2 && ({1'b0, c2} >= n));
    dup_err   = (use_t  && use_c1 && (t  == c1)) ||
                (use_t  && use_c2 && (t  == c2)) ||
                (use_c1 && use_c2 && (c1 == c2));

    if (code[3])        status = ST_BAD_OP;
    else if (range_err) status = ST_RANGE;
    else if (dup_err)   status = ST_DUP;
    else begin
      case (code)
        OP_X:       next_qreg[t] = ~qreg[t];
        OP_CNOT:    if (qreg[c1]) next_qreg[t] = ~qreg[t];
        OP_CCX:     if (qreg[c1] && qreg[c2]) next_qreg[t] = ~qreg[t];
        OP_SWAP:    begin next_qreg[t] = qreg[c1]; next_qreg[c1] = qreg[t]; end
        OP_LOAD:    next_qreg = load_state & mask;
        OP_PARITY:  parity = ^(qreg & mask);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/quantum_op_executor.sv
// Quantum-unit responder: executes latched operation requests against a persistent
// 16-qubit basis register and runs independent error-correction passes.
module quantum_op_executor
  import quantum_pkg::*;
#(
  parameter int EXEC_LATENCY = 4,
  parameter int EC_LATENCY   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   qop_code,
  input  logic [127:0] qop_param_flat,
  input  logic         qop_start,
  output logic         qop_done,
  output logic         qop_error,
  output logic [127:0] qop_result_flat,
  input  logic [3:0]   qubit_count,
  input  logic [15:0]  quantum_state,
  output logic [15:0]  quantum_result,
  output logic         quantum_valid,
  input  logic         error_correct_enable,
  output logic         error_correct_done,
  output logic         error_correct_success
);

  localparam int XW = $clog2(EXEC_LATENCY + 1);
  localparam int EW = $clog2(EC_LATENCY + 1);

  typedef enum logic [1:0] {OP_IDLE, OP_EXEC, OP_DONE} op_state_e;
  typedef enum logic [1:0] {EC_IDLE, EC_RUN, EC_WAIT} ec_state_e;

  op_state_e   op_state, op_next;
  ec_state_e   ec_state, ec_next;
  logic [XW-1:0] exec_cnt;
  logic [EW-1:0] ec_cnt;
  logic        exec_last, ec_last, commit, ec_finish;

  logic [15:0] qreg, qreg_commit, qreg_d, alu_next, state_q;
  logic [3:0]  code_q, t_q, c1_q, c2_q;
  logic [4:0]  n_q;
  logic [7:0]  op_cnt;
  logic        corr_flag, fatal_flag, corr_set, fatal_set, alu_parity;
  status_e     alu_status;
  logic [127:0] result_d;
  logic        unused_param;

  assign unused_param = ^{qop_param_flat[127:20], qop_param_flat[15:12], qop_param_flat[7:4]};

  quantum_gate_alu u_alu (
    .qreg       (qreg),
    .code       (code_q),
    .t          (t_q),
    .c1         (c1_q),
    .c2         (c2_q),
    .load_state (state_q),
    .n          (n_q),
    .next_qreg  (alu_next),
    .status     (alu_status),
    .parity     (alu_parity)
  );

  assign exec_last = (exec_cnt == XW'(EXEC_LATENCY));
  assign ec_last   = (ec_cnt == EW'(EC_LATENCY));
  assign commit    = (op_state == OP_EXEC) && exec_last;
  assign ec_finish = (ec_state == EC_RUN) && ec_last;

  // A correction pass finishing on a commit edge masks the freshly committed register.
  assign qreg_commit = commit ? alu_next : qreg;
  assign qreg_d      = ec_finish ? (qreg_commit & qubit_mask(n_q)) : qreg_commit;
  assign corr_set    = commit && ((alu_status == ST_RANGE) || (alu_status == ST_DUP));
  assign fatal_set   = commit && (alu_status == ST_BAD_OP);

  always_comb begin
    result_d = '0;
    result_d[8*RB_REG_LO +: 8] = alu_next[7:0];
    result_d[8*RB_REG_HI +: 8] = alu_next[15:8];
    result_d[8*RB_OPCODE +: 8] = {4'd0, code_q};
    result_d[8*RB_STATUS +: 8] = alu_status;
    result_d[8*RB_COUNT  +: 8] = op_cnt + 8'd1;
    result_d[8*RB_PARITY +: 8] = {7'd0, alu_parity};
  end

  always_comb begin
    op_next = op_state;
    case (op_state)
      OP_IDLE: if (qop_start)  op_next = OP_EXEC;
      OP_EXEC: if (exec_last)  op_next = OP_DONE;
      OP_DONE: if (!qop_start) op_next = OP_IDLE;
      default:                 op_next = OP_IDLE;
    endcase
  end

  always_comb begin
    ec_next = ec_state;
    case (ec_state)
      EC_IDLE: if (error_correct_enable)  ec_next = EC_RUN;
      EC_RUN:  if (ec_last)               ec_next = EC_WAIT;
      EC_WAIT: if (!error_correct_enable) ec_next = EC_IDLE;
      default:                            ec_next = EC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_state <= OP_IDLE;
      ec_state <= EC_IDLE;
      exec_cnt <= '0;
      ec_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
      op_state <= op_next;
      ec_state <= ec_next;
      exec_cnt <= (op_state == OP_EXEC && !exec_last) ? exec_cnt + XW'(1) : '0;
      ec_cnt   <= (ec_state == EC_RUN && !ec_last) ? ec_cnt + EW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qreg                  <= '0;
      code_q                <= '0;
      t_q                   <= '0;
      c1_q                  <= '0;
      c2_q                  <= '0;
      state_q               <= '0;
      n_q                   <= 5'd16;
      op_cnt                <= '0;
      corr_flag             <= 1'b0;
      fatal_flag            <= 1'b0;
      qop_error             <= 1'b0;
      qop_result_flat       <= '0;
      quantum_result        <= '0;
      error_correct_done    <= 1'b0;
      error_correct_success <= 1'b0;
    end else begin
      qop_error          <= 1'b0;
      error_correct_done <= 1'b0;
      qreg               <= qreg_d;
      if (op_state == OP_IDLE && qop_start) begin
        code_q  <= qop_code;
        t_q     <= qop_param_flat[3:0];
        c1_q    <= qop_param_flat[11:8];
        c2_q    <= qop_param_flat[19:16];
        state_q <= quantum_state;
        n_q     <= (qubit_count == 4'd0) ? 5'd16 : {1'b0, qubit_count};
      end
      if (commit) begin
        op_cnt          <= op_cnt + 8'd1;
        qop_result_flat <= result_d;
        quantum_result  <= alu_next;
        qop_error       <= (alu_status != ST_OK);
      end
      if (ec_finish) begin
        corr_flag             <= 1'b0;
        fatal_flag            <= 1'b0;
        error_correct_done    <= 1'b1;
        error_correct_success <= ~(fatal_flag | fatal_set);
      end else begin
        corr_flag  <= corr_flag | corr_set;
        fatal_flag <= fatal_flag | fatal_set;
      end
    end
  end

  assign qop_done      = (op_state == OP_DONE);
  assign quantum_valid = (op_state == OP_DONE);

endmodule

// File: tb/tb_quantum_op_executor.sv
// Directed self-checking bench for quantum_op_executor with hand-computed expectations.
module tb_quantum_op_executor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   qop_code = '0;
  logic [127:0] qop_param_flat = '0;
  logic         qop_start = 1'b0;
  logic         qop_done, qop_error, quantum_valid;
  logic [127:0] qop_result_flat;
  logic [3:0]   qubit_count = '0;
  logic [15:0]  quantum_state = '0;
  logic [15:0]  quantum_result;
  logic         error_correct_enable = 1'b0;
  logic         error_correct_done, error_correct_success;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quantum_op_executor #(.EXEC_LATENCY(4), .EC_LATENCY(3)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .qop_code              (qop_code),
    .qop_param_flat        (qop_param_flat),
    .qop_start             (qop_start),
    .qop_done              (qop_done),
    .qop_error             (qop_error),
    .qop_result_flat       (qop_result_flat),
    .qubit_count           (qubit_count),
    .quantum_state         (quantum_state),
    .quantum_result        (quantum_result),
    .quantum_valid         (quantum_valid),
    .error_correct_enable  (error_correct_enable),
    .error_correct_done    (error_correct_done),
    .error_correct_success (error_correct_success)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_res(input logic [15:0] r, input logic [3:0] code,
                                           input logic [7:0] st, input logic [7:0] cnt,
                                           input logic [7:0] par);
    return {80'h0, par, cnt, st, 4'h0, code, r};
  endfunction

  // Issues one request, scrambles the inputs during EXEC, waits for done (bounded),
  // holds start for 1+hold cycles in DONE, then drops it and checks done falls.
  task automatic do_op(input logic [3:0] code, input logic [3:0] t, input logic [3:0] c1,
                       input logic [3:0] c2, input logic [3:0] n, input logic [15:0] st,
                       input int hold, output int lat, output logic [127:0] res,
                       output logic [15:0] qr, output logic e0);
    @(negedge clk);
    qop_code              = code;
    qop_param_flat        = '0;
    qop_param_flat[3:0]   = t;
    qop_param_flat[11:8]  = c1;
    qop_param_flat[19:16] = c2;
    qubit_count           = n;
    quantum_state         = st;
    qop_start             = 1'b1;
    @(posedge clk); #1;
    qop_code       = 4'hE;
    qop_param_flat = '1;
    qubit_count    = 4'd1;
    quantum_state  = ~st;
    lat = 0;
    while (!qop_done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = qop_result_flat;
    qr  = quantum_result;
    e0  = qop_error;
    @(posedge clk); #1;
    check("err_pulse_end", {qop_error, qop_done}, 2'b01);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("done_held", {qop_done, quantum_valid}, 2'b11);
    end
    @(negedge clk);
    qop_start = 1'b0;
    @(posedge clk); #1;
    check("done_fall", {qop_done, quantum_valid}, 2'b00);
  endtask

  task automatic do_ec(output int lat, output logic succ);
    @(negedge clk);
    error_correct_enable = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!error_correct_done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    succ = error_correct_success;
    @(posedge clk); #1;
    check("ec_pulse_end", error_correct_done, 1'b0);
    @(negedge clk);
    error_correct_enable = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int            lat;
    logic [127:0]  res;
    logic [15:0]   qr;
    logic          e0, succ;

    #3;
    check("rst_flags", {qop_done, qop_error, quantum_valid, error_correct_done, error_correct_success}, 5'd0);
    check("rst_result", qop_result_flat, 128'd0);
    check("rst_qres", quantum_result, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 16'hA5C3, 0, lat, res, qr, e0);
    check("load_lat", lat, 5);
    check("load_res", res, exp_res(16'hA5C3, 4'd5, 8'd0, 8'd1, 8'd0));
    check("load_qres", qr, 16'hA5C3);
    check("load_err", e0, 1'b0);

    do_op(4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("meas_res", res, exp_res(16'hA5C3, 4'd6, 8'd0, 8'd2, 8'd0));

    do_op(4'd7, 4'd0, 4'd0, 4'd0, 4'd7, 16'h0000, 0, lat, res, qr, e0);
    check("parity_res", res, exp_res(16'hA5C3, 4'd7, 8'd0, 8'd3, 8'd1));

    do_op(4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0001, 0, lat, res, qr, e0);
    check("load1_qres", qr, 16'h0001);

    do_op(4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("cnot_res", res, exp_res(16'h0003, 4'd2, 8'd0, 8'd5, 8'd0));

    do_op(4'd3, 4'd4, 4'd0, 4'd1, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("ccx_res", res, exp_res(16'h0013, 4'd3, 8'd0, 8'd6, 8'd0));

    do_op(4'd4, 4'd0, 4'd8, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("swap_res", res, exp_res(16'h0112, 4'd4, 8'd0, 8'd7, 8'd0));
    check("swap_qres", qr, 16'h0112);

    do_op(4'd2, 4'd3, 4'd3, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("dup_res", res, exp_res(16'h0112, 4'd2, 8'd3, 8'd8, 8'd0));
    check("dup_err", e0, 1'b1);

    do_op(4'd1, 4'd9, 4'd0, 4'd0, 4'd8, 16'h0000, 0, lat, res, qr, e0);
    check("range_res", res, exp_res(16'h0112, 4'd1, 8'd2, 8'd9, 8'd0));
    check("range_err", e0, 1'b1);
    check("range_qres", qr, 16'h0112);

    do_ec(lat, succ);
    check("ec1_lat", lat, 4);
    check("ec1_success", succ, 1'b1);

    do_op(4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("ec_masked_res", res, exp_res(16'h0012, 4'd6, 8'd0, 8'd10, 8'd0));

    do_op(4'hB, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("badop_res", res, exp_res(16'h0012, 4'hB, 8'd1, 8'd11, 8'd0));
    check("badop_err", e0, 1'b1);

    do_ec(lat, succ);
    check("ec2_success", succ, 1'b0);
    do_ec(lat, succ);
    check("ec3_success", succ, 1'b1);

    do_op(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 3, lat, res, qr, e0);
    check("hold_res", res, exp_res(16'h0012, 4'd0, 8'd0, 8'd12, 8'd0));
    do_op(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("after_hold_cnt", res[39:32], 8'h0D);

    for (int i = 14; i <= 254; i++)
      do_op(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    do_op(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("cnt_255", res[39:32], 8'hFF);
    do_op(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("cnt_wrap", res[39:32], 8'h00);

    @(negedge clk);
    qop_code       = 4'd1;
    qop_param_flat = '0;
    qubit_count    = 4'd0;
    qop_start      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_flags", {qop_done, qop_error, quantum_valid, error_correct_done, error_correct_success}, 5'd0);
    check("mid_rst_result", qop_result_flat, 128'd0);
    check("mid_rst_qres", quantum_result, 16'd0);
    qop_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_op(4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 0, lat, res, qr, e0);
    check("post_rst_lat", lat, 5);
    check("post_rst_res", res, exp_res(16'h0000, 4'd6, 8'd0, 8'd1, 8'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
